// File: rtl/game_round_ctrl.sv
// Round sequencer for the Donkey-vs-Kong match: countdown, round timer,
// scoring and match winner, driven by a whole-second tick.
module game_round_ctrl #(
   parameter int CLK_HZ      = 65_000_000,
   parameter int COUNTDOWN_S = 3,
   parameter int ROUND_S     = 60,
   parameter int RESULT_S    = 2,
   parameter int WIN_ROUNDS  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic       touch_lady,
   input  logic       donkey_hit,
   output logic       game_en,
   output logic       pos_reset,
   output logic [1:0] countdown,
   output logic [6:0] time_left,
   output logic [1:0] score_donkey,
   output logic [1:0] score_kong,
   output logic [1:0] round_winner,
   output logic       match_over,
   output logic [2:0] state_dbg
);

   localparam int DW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_HZ - 1);
   localparam logic [1:0]    CD_INIT  = 2'(COUNTDOWN_S);
   localparam logic [6:0]    TL_INIT  = 7'(ROUND_S);
   localparam logic [3:0]    RES_LAST = 4'(RESULT_S - 1);
   localparam logic [1:0]    WIN_N    = 2'(WIN_ROUNDS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CD   = 3'd1,
      S_PLAY = 3'd2,
      S_RES  = 3'd3,
      S_END  = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic          start_q;
   logic [1:0]    cd_q, cd_d;
   logic [6:0]    tl_q, tl_d;
   logic [1:0]    sd_q, sd_d;
   logic [1:0]    sk_q, sk_d;
   logic [1:0]    win_q, win_d;
   logic          pr_q, pr_d;
   logic [3:0]    res_q, res_d;

   logic sec_tick;
   logic start_rise;

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   assign sec_tick   = (div_q == DIV_LAST);
   assign start_rise = start_btn & ~start_q;

   // Next-state, round bookkeeping and the entry-relative second divider
   always_comb begin
      state_d = state_q;
      cd_d    = cd_q;
      tl_d    = tl_q;
      sd_d    = sd_q;
      sk_d    = sk_q;
      win_d   = win_q;
      pr_d    = 1'b0;
      res_d   = res_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_rise) begin
               state_d = S_CD;
               sd_d    = 2'd0;
               sk_d    = 2'd0;
               win_d   = 2'b00;
               cd_d    = CD_INIT;
               tl_d    = TL_INIT;
               pr_d    = 1'b1;
            end
         end
         S_CD: begin
            if (sec_tick) begin
               if (cd_q <= 2'd1) begin
                  state_d = S_PLAY;
                  cd_d    = 2'd0;
               end else begin
                  cd_d = cd_q - 2'd1;
               end
            end
         end
         S_PLAY: begin
            if (touch_lady) begin
               state_d = S_RES;
               win_d   = 2'b01;
               sd_d    = sat_inc(sd_q);
            end else if (donkey_hit) begin
               state_d = S_RES;
               win_d   = 2'b10;
               sk_d    = sat_inc(sk_q);
            end else if (sec_tick) begin
               if (tl_q <= 7'd1) begin
                  state_d = S_RES;
                  win_d   = 2'b10;
                  sk_d    = sat_inc(sk_q);
                  tl_d    = 7'd0;
               end else begin
                  tl_d = tl_q - 7'd1;
               end
            end
         end
         S_RES: begin
            if (sec_tick) begin
               if (res_q == RES_LAST) begin
                  if (sd_q == WIN_N || sk_q == WIN_N) begin
                     state_d = S_END;
                  end else begin
                     state_d = S_CD;
                     cd_d    = CD_INIT;
                     tl_d    = TL_INIT;
                     win_d   = 2'b00;
                     pr_d    = 1'b1;
                  end
               end else begin
                  res_d = res_q + 4'd1;
               end
            end
         end
         S_END: begin
            if (start_rise) begin
               state_d = S_IDLE;
               sd_d    = 2'd0;
               sk_d    = 2'd0;
               win_d   = 2'b00;
               cd_d    = 2'd0;
               tl_d    = TL_INIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) res_d = 4'd0;
      if (state_d != state_q || sec_tick) div_d = '0;
      else div_d = div_q + DW'(1);
   end

   // State and round registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         start_q <= 1'b0;
         cd_q    <= 2'd0;
         tl_q    <= TL_INIT;
         sd_q    <= 2'd0;
         sk_q    <= 2'd0;
         win_q   <= 2'b00;
         pr_q    <= 1'b0;
         res_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         start_q <= start_btn;
         cd_q    <= cd_d;
         tl_q    <= tl_d;
         sd_q    <= sd_d;
         sk_q    <= sk_d;
         win_q   <= win_d;
         pr_q    <= pr_d;
         res_q   <= res_d;
      end
   end

   assign game_en      = (state_q == S_PLAY);
   assign match_over   = (state_q == S_END);
   assign state_dbg    = state_q;
   assign pos_reset    = pr_q;
   assign countdown    = cd_q;
   assign time_left    = tl_q;
   assign score_donkey = sd_q;
   assign score_kong   = sk_q;
   assign round_winner = win_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: directed scenarios with constant expectations,
// then random stimulus against a cycles-since-entry reference model.
module tb_game_round_ctrl;

   localparam int CLK_HZ      = 10;
   localparam int COUNTDOWN_S = 2;
   localparam int ROUND_S     = 5;
   localparam int RESULT_S    = 1;
   localparam int WIN_ROUNDS  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_btn;
   logic       touch_lady;
   logic       donkey_hit;
   logic       game_en;
   logic       pos_reset;
   logic [1:0] countdown;
   logic [6:0] time_left;
   logic [1:0] score_donkey;
   logic [1:0] score_kong;
   logic [1:0] round_winner;
   logic       match_over;
   logic [2:0] state_dbg;

   int checks   = 0;
   int failures = 0;

   // reference model: phase, cycles since phase entry, round bookkeeping
   int m_st  = 0;
   int m_cyc = 0;
   int m_sd  = 0;
   int m_sk  = 0;
   int m_w   = 0;
   int m_tl  = ROUND_S;
   bit m_pr  = 0;
   bit m_sb  = 0;

   game_round_ctrl #(
      .CLK_HZ(CLK_HZ),
      .COUNTDOWN_S(COUNTDOWN_S),
      .ROUND_S(ROUND_S),
      .RESULT_S(RESULT_S),
      .WIN_ROUNDS(WIN_ROUNDS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start_btn(start_btn),
      .touch_lady(touch_lady),
      .donkey_hit(donkey_hit),
      .game_en(game_en),
      .pos_reset(pos_reset),
      .countdown(countdown),
      .time_left(time_left),
      .score_donkey(score_donkey),
      .score_kong(score_kong),
      .round_winner(round_winner),
      .match_over(match_over),
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   function automatic int inc3(input int v);
      return (v < 3) ? v + 1 : 3;
   endfunction

   // one clock of the rules, using the inputs the DUT just sampled
   function automatic void model_step();
      int  ns;
      bit  rise;
      rise = start_btn && !m_sb;
      ns   = m_st;
      m_pr = 0;
      if (rst) begin
         ns = 0; m_sd = 0; m_sk = 0; m_w = 0; m_tl = ROUND_S;
      end else begin
         case (m_st)
            0: if (rise) begin
               ns = 1; m_sd = 0; m_sk = 0; m_w = 0;
               m_tl = ROUND_S; m_pr = 1;
            end
            1: if (m_cyc == COUNTDOWN_S * CLK_HZ - 1) ns = 2;
            2: begin
               if (touch_lady) begin
                  ns = 3; m_w = 1; m_sd = inc3(m_sd);
                  m_tl = ROUND_S - m_cyc / CLK_HZ;
               end else if (donkey_hit) begin
                  ns = 3; m_w = 2; m_sk = inc3(m_sk);
                  m_tl = ROUND_S - m_cyc / CLK_HZ;
               end else if (m_cyc == ROUND_S * CLK_HZ - 1) begin
                  ns = 3; m_w = 2; m_sk = inc3(m_sk); m_tl = 0;
               end
            end
            3: if (m_cyc == RESULT_S * CLK_HZ - 1) begin
               if (m_sd == WIN_ROUNDS || m_sk == WIN_ROUNDS) ns = 4;
               else begin
                  ns = 1; m_w = 0; m_pr = 1; m_tl = ROUND_S;
               end
            end
            4: if (rise) begin
               ns = 0; m_sd = 0; m_sk = 0; m_w = 0; m_tl = ROUND_S;
            end
            default: ns = 0;
         endcase
      end
      m_sb  = rst ? 1'b0 : start_btn;
      m_cyc = (rst || ns != m_st) ? 0 : m_cyc + 1;
      m_st  = ns;
   endfunction

   function automatic logic [20:0] model_out();
      int cd;
      int tl;
      cd = (m_st == 1) ? COUNTDOWN_S - m_cyc / CLK_HZ : 0;
      tl = (m_st == 2) ? ROUND_S - m_cyc / CLK_HZ : m_tl;
      return {3'(m_st), (m_st == 2), m_pr, 2'(cd), 7'(tl),
              2'(m_sd), 2'(m_sk), 2'(m_w), (m_st == 4)};
   endfunction

   // advance n clocks; inputs change and outputs are read on negedges
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(2);
      checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_dbg); end
      checks++; if (game_en !== 1'b0) begin failures++; $display("FAIL rst_game_en got=%0d exp=0", game_en); end
      checks++; if (pos_reset !== 1'b0) begin failures++; $display("FAIL rst_pos_reset got=%0d exp=0", pos_reset); end
      checks++; if (countdown !== 2'd0) begin failures++; $display("FAIL rst_countdown got=%0d exp=0", countdown); end
      checks++; if (time_left !== 7'd5) begin failures++; $display("FAIL rst_time_left got=%0d exp=5", time_left); end
      checks++; if (score_donkey !== 2'd0) begin failures++; $display("FAIL rst_score_d got=%0d exp=0", score_donkey); end
      checks++; if (score_kong !== 2'd0) begin failures++; $display("FAIL rst_score_k got=%0d exp=0", score_kong); end
      checks++; if (round_winner !== 2'd0) begin failures++; $display("FAIL rst_winner got=%0d exp=0", round_winner); end
      checks++; if (match_over !== 1'b0) begin failures++; $display("FAIL rst_match_over got=%0d exp=0", match_over); end
      rst = 1'b0;
   endtask

   task automatic test_start_countdown();
      start_btn = 1'b1;
      tick(1);
      checks++; if (pos_reset !== 1'b1) begin failures++; $display("FAIL cd_pos_reset got=%0d exp=1", pos_reset); end
      checks++; if (state_dbg !== 3'd1) begin failures++; $display("FAIL cd_state got=%0d exp=1", state_dbg); end
      checks++; if (countdown !== 2'd2) begin failures++; $display("FAIL cd_first got=%0d exp=2", countdown); end
      tick(1);
      checks++; if (pos_reset !== 1'b0) begin failures++; $display("FAIL cd_pulse_len got=%0d exp=0", pos_reset); end
      tick(8);
      checks++; if (countdown !== 2'd2) begin failures++; $display("FAIL cd_before_tick got=%0d exp=2", countdown); end
      tick(1);
      checks++; if (countdown !== 2'd1) begin failures++; $display("FAIL cd_second got=%0d exp=1", countdown); end
      tick(9);
      checks++; if (game_en !== 1'b0) begin failures++; $display("FAIL cd_early_en got=%0d exp=0", game_en); end
      tick(1);
      checks++; if (game_en !== 1'b1) begin failures++; $display("FAIL play_en got=%0d exp=1", game_en); end
      checks++; if (state_dbg !== 3'd2) begin failures++; $display("FAIL play_state got=%0d exp=2", state_dbg); end
      checks++; if (countdown !== 2'd0) begin failures++; $display("FAIL play_countdown got=%0d exp=0", countdown); end
      checks++; if (time_left !== 7'd5) begin failures++; $display("FAIL play_time_left got=%0d exp=5", time_left); end
   endtask

   task automatic test_donkey_win();
      int d;
      d = $urandom_range(0, 15);
      start_btn = 1'b0;
      tick(d);
      touch_lady = 1'b1;
      tick(1);
      checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL dw_state got=%0d exp=3", state_dbg); end
      checks++; if (score_donkey !== 2'd1) begin failures++; $display("FAIL dw_score_d got=%0d exp=1", score_donkey); end
      checks++; if (score_kong !== 2'd0) begin failures++; $display("FAIL dw_score_k got=%0d exp=0", score_kong); end
      checks++; if (round_winner !== 2'b01) begin failures++; $display("FAIL dw_winner got=%0d exp=1", round_winner); end
      checks++; if (game_en !== 1'b0) begin failures++; $display("FAIL dw_game_en got=%0d exp=0", game_en); end
      checks++; if (time_left !== 7'(5 - d / 10)) begin failures++; $display("FAIL dw_time_left got=%0d exp=%0d", time_left, 5 - d / 10); end
      tick(9);
      checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL dw_hold got=%0d exp=3", state_dbg); end
      checks++; if (score_donkey !== 2'd1) begin failures++; $display("FAIL dw_flag_ignored got=%0d exp=1", score_donkey); end
      tick(1);
      touch_lady = 1'b0;
      checks++; if (state_dbg !== 3'd1) begin failures++; $display("FAIL dw_next_state got=%0d exp=1", state_dbg); end
      checks++; if (time_left !== 7'd5) begin failures++; $display("FAIL dw_reload got=%0d exp=5", time_left); end
      checks++; if (round_winner !== 2'b00) begin failures++; $display("FAIL dw_winner_clr got=%0d exp=0", round_winner); end
      checks++; if (pos_reset !== 1'b1) begin failures++; $display("FAIL dw_pos_reset got=%0d exp=1", pos_reset); end
      checks++; if (countdown !== 2'd2) begin failures++; $display("FAIL dw_countdown got=%0d exp=2", countdown); end
   endtask

   task automatic test_timeout();
      tick(20);
      checks++; if (state_dbg !== 3'd2) begin failures++; $display("FAIL to_play got=%0d exp=2", state_dbg); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (time_left !== 7'(5 - k)) begin failures++; $display("FAIL to_step%0d got=%0d exp=%0d", k, time_left, 5 - k); end
         tick(10);
      end
      checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL to_state got=%0d exp=3", state_dbg); end
      checks++; if (score_kong !== 2'd1) begin failures++; $display("FAIL to_score_k got=%0d exp=1", score_kong); end
      checks++; if (time_left !== 7'd0) begin failures++; $display("FAIL to_time_left got=%0d exp=0", time_left); end
      checks++; if (round_winner !== 2'b10) begin failures++; $display("FAIL to_winner got=%0d exp=2", round_winner); end
      tick(10);
      checks++; if (state_dbg !== 3'd1) begin failures++; $display("FAIL to_next_state got=%0d exp=1", state_dbg); end
   endtask

   task automatic test_simultaneous();
      tick(69);
      checks++; if (time_left !== 7'd1) begin failures++; $display("FAIL sim_pre got=%0d exp=1", time_left); end
      touch_lady = 1'b1;
      donkey_hit = 1'b1;
      tick(1);
      touch_lady = 1'b0;
      donkey_hit = 1'b0;
      checks++; if (score_donkey !== 2'd2) begin failures++; $display("FAIL sim_score_d got=%0d exp=2", score_donkey); end
      checks++; if (score_kong !== 2'd1) begin failures++; $display("FAIL sim_score_k got=%0d exp=1", score_kong); end
      checks++; if (round_winner !== 2'b01) begin failures++; $display("FAIL sim_winner got=%0d exp=1", round_winner); end
      checks++; if (time_left !== 7'd1) begin failures++; $display("FAIL sim_time_left got=%0d exp=1", time_left); end
   endtask

   task automatic test_match_end();
      start_btn = 1'b1;
      tick(9);
      checks++; if (state_dbg !== 3'd3) begin failures++; $display("FAIL me_result got=%0d exp=3", state_dbg); end
      checks++; if (match_over !== 1'b0) begin failures++; $display("FAIL me_early got=%0d exp=0", match_over); end
      tick(1);
      checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL me_state got=%0d exp=4", state_dbg); end
      checks++; if (match_over !== 1'b1) begin failures++; $display("FAIL me_over got=%0d exp=1", match_over); end
      checks++; if (round_winner !== 2'b01) begin failures++; $display("FAIL me_winner got=%0d exp=1", round_winner); end
      tick(5);
      checks++; if (state_dbg !== 3'd4) begin failures++; $display("FAIL me_held got=%0d exp=4", state_dbg); end
      start_btn = 1'b0;
      tick(2);
      start_btn = 1'b1;
      tick(1);
      start_btn = 1'b0;
      checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL me_restart got=%0d exp=0", state_dbg); end
      checks++; if (score_donkey !== 2'd0) begin failures++; $display("FAIL me_score_d got=%0d exp=0", score_donkey); end
      checks++; if (score_kong !== 2'd0) begin failures++; $display("FAIL me_score_k got=%0d exp=0", score_kong); end
      checks++; if (match_over !== 1'b0) begin failures++; $display("FAIL me_over_clr got=%0d exp=0", match_over); end
      checks++; if (round_winner !== 2'b00) begin failures++; $display("FAIL me_winner_clr got=%0d exp=0", round_winner); end
      checks++; if (time_left !== 7'd5) begin failures++; $display("FAIL me_time_left got=%0d exp=5", time_left); end
   endtask

   task automatic test_reset_mid_play();
      tick(1);
      start_btn = 1'b1;
      tick(1);
      start_btn = 1'b0;
      tick(20);
      donkey_hit = 1'b1;
      tick(1);
      donkey_hit = 1'b0;
      checks++; if (round_winner !== 2'b10) begin failures++; $display("FAIL rm_hit_winner got=%0d exp=2", round_winner); end
      tick(50);
      checks++; if (time_left !== 7'd3) begin failures++; $display("FAIL rm_time_left got=%0d exp=3", time_left); end
      checks++; if (score_kong !== 2'd1) begin failures++; $display("FAIL rm_score_k got=%0d exp=1", score_kong); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rm_state got=%0d exp=0", state_dbg); end
      checks++; if (score_kong !== 2'd0) begin failures++; $display("FAIL rm_score_k0 got=%0d exp=0", score_kong); end
      checks++; if (time_left !== 7'd5) begin failures++; $display("FAIL rm_time_left5 got=%0d exp=5", time_left); end
      checks++; if (game_en !== 1'b0) begin failures++; $display("FAIL rm_game_en got=%0d exp=0", game_en); end
      touch_lady = 1'b1;
      donkey_hit = 1'b1;
      tick(5);
      touch_lady = 1'b0;
      donkey_hit = 1'b0;
      checks++; if (score_donkey !== 2'd0) begin failures++; $display("FAIL rm_idle_d got=%0d exp=0", score_donkey); end
      checks++; if (score_kong !== 2'd0) begin failures++; $display("FAIL rm_idle_k got=%0d exp=0", score_kong); end
      checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rm_idle_state got=%0d exp=0", state_dbg); end
   endtask

   task automatic test_random();
      logic [20:0] got;
      logic [20:0] exp;
      for (int i = 0; i < 4000; i++) begin
         got = {state_dbg, game_en, pos_reset, countdown, time_left,
                score_donkey, score_kong, round_winner, match_over};
         exp = model_out();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL rand_cycle%0d got=%h exp=%h", i, got, exp);
         end
         if ($urandom_range(0, 9) == 0) start_btn = ~start_btn;
         touch_lady = ($urandom_range(0, 59) == 0);
         donkey_hit = ($urandom_range(0, 49) == 0);
         rst        = ($urandom_range(0, 799) == 0);
         tick(1);
      end
      rst        = 1'b0;
      touch_lady = 1'b0;
      donkey_hit = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start_btn  = 1'b0;
      touch_lady = 1'b0;
      donkey_hit = 1'b0;
      @(negedge clk);
      test_reset();
      test_start_countdown();
      test_donkey_win();
      test_timeout();
      test_simultaneous();
      test_match_end();
      test_reset_mid_play();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
